// File: rtl/router_delivery_arbiter.sv
// router_delivery_arbiter
//   Schedules bit-serial message delivery from NUM_BUF message buffers onto
//   NUM_CELL cell lines. Each cycle, idle requesting buffers whose destination
//   cell is free are granted in round-robin order. A grant is then held for
//   exactly MSG_LEN bit-times, unless the request drops first.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   req       in   [NUM_BUF]         buffer i holds a message (level)
//   addr      in   [NUM_BUF*ADDR_W]  destination cell of buffer i
//   sel       out  [NUM_BUF]         distributor select, buffer i -> cell addr_q[i]
//   shift     out  [NUM_BUF]         buffer i advances to its next bit
//   done      out  [NUM_BUF]         pulse on buffer i's last bit
//   cell_busy out  [NUM_CELL]        cell c is being delivered to
//   rr_ptr    out  [3]               current highest-priority buffer (debug)
module router_delivery_arbiter #(
  parameter int NUM_BUF  = 7,
  parameter int NUM_CELL = 16,
  parameter int ADDR_W   = 4,
  parameter int MSG_LEN  = 32,
  parameter int CNT_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BUF-1:0]        req,
  input  logic [NUM_BUF*ADDR_W-1:0] addr,
  output logic [NUM_BUF-1:0]        sel,
  output logic [NUM_BUF-1:0]        shift,
  output logic [NUM_BUF-1:0]        done,
  output logic [NUM_CELL-1:0]       cell_busy,
  output logic [2:0]                rr_ptr
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} st_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_LEN - 1);

  st_e                 state_r      [NUM_BUF];
  st_e                 state_nxt_s  [NUM_BUF];
  logic [CNT_W-1:0]    cnt_r        [NUM_BUF];
  logic [CNT_W-1:0]    cnt_nxt_s    [NUM_BUF];
  logic [ADDR_W-1:0]   addr_q_r     [NUM_BUF];
  logic [ADDR_W-1:0]   addr_q_nxt_s [NUM_BUF];

  logic [2:0]          rr_ptr_r, rr_ptr_nxt_s, last_s;
  logic                any_grant_s;
  logic [NUM_BUF-1:0]  grant_s;
  logic [NUM_BUF-1:0]  sel_r, sel_nxt_s, done_r, done_nxt_s;
  logic [NUM_CELL-1:0] busy_r, busy_nxt_s, held_s, claimed_s;

  function automatic logic [NUM_CELL-1:0] cell_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_CELL-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Cells still owned next cycle: a sender in its done cycle or with its
  // request withdrawn releases its cell now, which allows gapless handover.
  always_comb begin
    held_s = '0;
    for (int j = 0; j < NUM_BUF; j++) begin
      if ((state_r[j] == ST_SEND) && req[j] && !done_r[j]) begin
        held_s = held_s | cell_onehot(addr_q_r[j]);
      end else begin
        held_s = held_s;
      end
    end
  end

  // Round-robin scan from rr_ptr; each grant claims its cell so later
  // buffers in the same scan cannot collide on it.
  always_comb begin
    grant_s     = '0;
    claimed_s   = held_s;
    any_grant_s = 1'b0;
    last_s      = rr_ptr_r;
    for (int k = 0; k < NUM_BUF; k++) begin
      for (int j = 0; j < NUM_BUF; j++) begin
        if (((int'(rr_ptr_r) + k) == j) || ((int'(rr_ptr_r) + k) == (j + NUM_BUF))) begin
          if (req[j] && (state_r[j] == ST_IDLE) &&
              ((claimed_s & cell_onehot(addr[j*ADDR_W +: ADDR_W])) == '0)) begin
            grant_s[j]  = 1'b1;
            claimed_s   = claimed_s | cell_onehot(addr[j*ADDR_W +: ADDR_W]);
            any_grant_s = 1'b1;
            last_s      = 3'(j);
          end else begin
            any_grant_s = any_grant_s;
          end
        end else begin
          any_grant_s = any_grant_s;
        end
      end
    end
    if (!any_grant_s) begin
      rr_ptr_nxt_s = rr_ptr_r;
    end else if (last_s == 3'(NUM_BUF - 1)) begin
      rr_ptr_nxt_s = 3'd0;
    end else begin
      rr_ptr_nxt_s = last_s + 3'd1;
    end
  end

  // Per-buffer next state: latch address on grant, end on last bit or abort.
  always_comb begin
    for (int i = 0; i < NUM_BUF; i++) begin
      state_nxt_s[i]  = state_r[i];
      cnt_nxt_s[i]    = cnt_r[i];
      addr_q_nxt_s[i] = addr_q_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (grant_s[i]) begin
            state_nxt_s[i]  = ST_SEND;
            cnt_nxt_s[i]    = '0;
            addr_q_nxt_s[i] = addr[i*ADDR_W +: ADDR_W];
          end else begin
            state_nxt_s[i]  = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (!req[i] || (cnt_r[i] == CNT_LAST)) begin
            state_nxt_s[i] = ST_IDLE;
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_W'(1'b1);
          end
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from next state so the
  // outputs themselves come straight from flops.
  always_comb begin
    sel_nxt_s  = '0;
    done_nxt_s = '0;
    busy_nxt_s = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (state_nxt_s[i] == ST_SEND) begin
        sel_nxt_s[i]  = 1'b1;
        done_nxt_s[i] = (cnt_nxt_s[i] == CNT_LAST);
        busy_nxt_s    = busy_nxt_s | cell_onehot(addr_q_nxt_s[i]);
      end else begin
        sel_nxt_s[i]  = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        state_r[i]  <= ST_IDLE;
        cnt_r[i]    <= '0;
        addr_q_r[i] <= '0;
      end
      rr_ptr_r <= 3'd0;
      sel_r    <= '0;
      done_r   <= '0;
      busy_r   <= '0;
    end else begin
      for (int i = 0; i < NUM_BUF; i++) begin
        state_r[i]  <= state_nxt_s[i];
        cnt_r[i]    <= cnt_nxt_s[i];
        addr_q_r[i] <= addr_q_nxt_s[i];
      end
      rr_ptr_r <= rr_ptr_nxt_s;
      sel_r    <= sel_nxt_s;
      done_r   <= done_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign sel       = sel_r;
  assign shift     = sel_r;
  assign done      = done_r;
  assign cell_busy = busy_r;
  assign rr_ptr    = rr_ptr_r;

endmodule

// File: tb/tb_router_delivery_arbiter.sv
module tb_router_delivery_arbiter;

  localparam int NB = 7;
  localparam int NC = 16;
  localparam int AW = 4;
  localparam int ML = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] req = '0;
  logic [NB*AW-1:0] addr = '0;
  logic [NB-1:0] sel, shift, done;
  logic [NC-1:0] cell_busy;
  logic [2:0]    rr_ptr;

  router_delivery_arbiter #(
    .NUM_BUF(NB), .NUM_CELL(NC), .ADDR_W(AW), .MSG_LEN(ML), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .sel(sel), .shift(shift), .done(done),
    .cell_busy(cell_busy), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  sel;
    logic [6:0]  done;
    logic [15:0] busy;
    logic [2:0]  ptr;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n, input logic [6:0] s, input logic [6:0] d,
                          input logic [15:0] b, input logic [2:0] p);
    exp_t e;
    e.sel = s; e.done = d; e.busy = b; e.ptr = p;
    for (int i = 0; i < n; i++) expq.push_back(e);
  endtask

  task automatic set_addr(input int i, input logic [3:0] a);
    addr[i*AW +: AW] = a;
  endtask

  // Drive this cycle's request, cross the edge, compare the next cycle.
  task automatic step(input logic [6:0] r, input string tag);
    exp_t e;
    req = r;
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      check_val({tag, ".queue"}, 32'(expq.size()), 32'd1);
      e = '0;
    end else begin
      e = expq.pop_front();
    end
    check_val({tag, ".sel"},   32'(sel),       32'(e.sel));
    check_val({tag, ".shift"}, 32'(shift),     32'(e.sel));
    check_val({tag, ".done"},  32'(done),      32'(e.done));
    check_val({tag, ".busy"},  32'(cell_busy), 32'(e.busy));
    check_val({tag, ".ptr"},   32'(rr_ptr),    32'(e.ptr));
  endtask

  task automatic do_reset();
    req  = '0;
    addr = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".sel"},   32'(sel),       32'd0);
    check_val({tag, ".shift"}, 32'(shift),     32'd0);
    check_val({tag, ".done"},  32'(done),      32'd0);
    check_val({tag, ".busy"},  32'(cell_busy), 32'd0);
    check_val({tag, ".ptr"},   32'(rr_ptr),    32'd0);
  endtask

  initial begin
    do_reset();
    check_zero("reset");

    // Single buffer 2 -> cell 5; addr change mid-message must be ignored.
    set_addr(2, 4'd5);
    push_exp(3, 7'h04, 7'h00, 16'h0020, 3'd3);
    push_exp(1, 7'h04, 7'h04, 16'h0020, 3'd3);
    push_exp(1, 7'h00, 7'h00, 16'h0000, 3'd3);
    step(7'h04, "single");
    set_addr(2, 4'd9);
    step(7'h04, "single");
    step(7'h04, "single");
    step(7'h04, "single");
    step(7'h00, "single");

    // Buffers 0 and 3 both to cell 9: back-to-back, no overlap.
    do_reset();
    set_addr(0, 4'd9);
    set_addr(3, 4'd9);
    push_exp(3, 7'h01, 7'h00, 16'h0200, 3'd1);
    push_exp(1, 7'h01, 7'h01, 16'h0200, 3'd1);
    push_exp(3, 7'h08, 7'h00, 16'h0200, 3'd4);
    push_exp(1, 7'h08, 7'h08, 16'h0200, 3'd4);
    push_exp(1, 7'h00, 7'h00, 16'h0000, 3'd4);
    repeat (4) step(7'h09, "conflict");
    repeat (4) step(7'h08, "conflict");
    step(7'h00, "conflict");

    // Buffers 1..6 to cells 0..5 all at once; pointer wraps to 0.
    do_reset();
    for (int i = 1; i < NB; i++) set_addr(i, 4'(i - 1));
    push_exp(3, 7'h7E, 7'h00, 16'h003F, 3'd0);
    push_exp(1, 7'h7E, 7'h7E, 16'h003F, 3'd0);
    push_exp(1, 7'h00, 7'h00, 16'h0000, 3'd0);
    repeat (4) step(7'h7E, "parallel");
    step(7'h00, "parallel");

    // Buffers 1 and 4 contend for cell 7: grants alternate 1,4,1,4.
    do_reset();
    set_addr(1, 4'd7);
    set_addr(4, 4'd7);
    for (int r = 0; r < 2; r++) begin
      push_exp(3, 7'h02, 7'h00, 16'h0080, 3'd2);
      push_exp(1, 7'h02, 7'h02, 16'h0080, 3'd2);
      push_exp(3, 7'h10, 7'h00, 16'h0080, 3'd5);
      push_exp(1, 7'h10, 7'h10, 16'h0080, 3'd5);
    end
    push_exp(1, 7'h00, 7'h00, 16'h0000, 3'd5);
    repeat (16) step(7'h12, "fair");
    step(7'h00, "fair");

    // Buffer 5 aborts in cycle 2; buffer 6 (same cell) takes over gaplessly.
    do_reset();
    set_addr(5, 4'd3);
    set_addr(6, 4'd3);
    push_exp(2, 7'h20, 7'h00, 16'h0008, 3'd6);
    push_exp(3, 7'h40, 7'h00, 16'h0008, 3'd0);
    push_exp(1, 7'h40, 7'h40, 16'h0008, 3'd0);
    push_exp(1, 7'h00, 7'h00, 16'h0000, 3'd0);
    repeat (2) step(7'h60, "abort");
    repeat (4) step(7'h40, "abort");
    step(7'h00, "abort");

    // Asynchronous reset in cycle 2, between clock edges.
    do_reset();
    set_addr(2, 4'd5);
    push_exp(2, 7'h04, 7'h00, 16'h0020, 3'd3);
    step(7'h04, "pre_arst");
    step(7'h04, "pre_arst");
    #2 rst = 1'b1;
    #1;
    check_zero("arst");
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp(3, 7'h00, 7'h00, 16'h0000, 3'd0);
    repeat (3) step(7'h00, "post_arst");

    check_val("leftover", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_delivery_arbiter.md
Name: router_delivery_arbiter

Overview:
- Schedules bit-serial message delivery from the 7 router message buffers onto the 16 cell lines through the distributor.
- Each cycle, grants waiting buffers whose destination cell is free, in round-robin order.
- Drives the per-buffer select flags the distributor consumes, and holds each grant for exactly MSG_LEN bit-times.
- Advances each granted buffer's bit pointer and reports completion.

Parameters:
- NUM_BUF, 7, number of message buffers (requesters).
- NUM_CELL, 16, number of cell lines.
- ADDR_W, 4, cell address width; NUM_CELL = 2**ADDR_W.
- MSG_LEN, 32, bits per message (legal range 2..63).
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > MSG_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_BUF  buffer i holds a message for delivery (level).
- addr  in  NUM_BUF*ADDR_W  destination cell of buffer i at bits [i*ADDR_W +: ADDR_W]; valid whenever req[i]=1.
- sel  out  NUM_BUF  select flag to distributor; buffer i's bit drives cell addr_q[i].
- shift  out  NUM_BUF  buffer i advances to its next message bit at end of cycle.
- done  out  NUM_BUF  one-cycle pulse coincident with buffer i's last bit.
- cell_busy  out  NUM_CELL  bit c=1 while any buffer is delivering to cell c.
- rr_ptr  out  3  current highest-priority buffer index (debug).

Behaviour:
- Reset (async, active-high): all per-buffer state IDLE; sel, shift, done, cell_busy = 0; rr_ptr = 0; latched addresses = 0.
- Per-buffer FSM states: IDLE and SEND. Counter cnt[i] has CNT_W bits.
- IDLE -> SEND when buffer i wins arbitration. On that edge: addr_q[i] <= addr[i]; cnt[i] <= 0.
- SEND outputs: sel[i]=1 and shift[i]=1 on every SEND cycle; cnt increments each cycle.
- done[i]=1 when cnt[i]==MSG_LEN-1. SEND -> IDLE after that cycle, so the grant lasts exactly MSG_LEN cycles.
- Latency: a request that wins in cycle t has sel high in cycles t+1 .. t+MSG_LEN. done is high in cycle t+MSG_LEN.
- Abort: if req[i] falls while buffer i is in SEND, then SEND -> IDLE on the next edge. No done pulse; the cell is freed. sel/shift stay high in the cycle req is observed low (registered outputs).
- Eligibility: buffer i is eligible in cycle t if req[i]=1, it is IDLE, and it is not in its done cycle. A buffer's own done cycle never re-grants it.
- Cell availability: a cell is free if no SEND buffer targets it, or the only SEND buffer targeting it has done=1 or req=0 this cycle. This allows gapless back-to-back delivery to the same cell.
- Grant order: scan buffers rr_ptr, rr_ptr+1, ... modulo NUM_BUF. Grant each eligible buffer whose addr targets a free cell not already claimed by an earlier grant this cycle. Multiple buffers to distinct cells may be granted in the same cycle.
- Pointer: rr_ptr <= (index of last granted buffer in scan order + 1) mod NUM_BUF. Unchanged if no grant. Wraps 6 -> 0.
- Invariant: at most one sel bit is high per destination cell in any cycle. The verifier asserts this every cycle.
- cell_busy is registered and is the OR of decoded addr_q over SEND buffers.
- addr changes while in SEND are ignored; the latched addr_q is used.
- Reset asserted mid-message: immediate return to reset values, no done pulse.

Test Plan:
- Bench MSG_LEN=4 throughout.
- Single buffer: req[2]=1, addr=5 at cycle 0 -> sel[2]=shift[2]=1 in cycles 1..4; done[2]=1 in cycle 4 only; cell_busy=16'h0020 in cycles 1..4; rr_ptr=3 from cycle 1.
- Conflict: req[0] and req[3] both addr=9 at cycle 0, rr_ptr=0 -> buffer 0 sends cycles 1..4; buffer 3 sends cycles 5..8 with no gap; no cycle has both sel[0] and sel[3] high.
- Parallel grant: req[1..6] with addrs 0,1,2,3,4,5 at cycle 0 -> all six sel high in cycles 1..4; rr_ptr=0 after grant (wrap from 6).
- Fairness: buffers 1 and 4 repeatedly request cell 7 -> grants alternate 1,4,1,4; each waits at most one message time.
- Abort: buffer 5 granted at cycle 0, req[5] dropped in cycle 2 -> sel[5] low from cycle 3; no done[5]; a waiting buffer to the same cell is granted in cycle 2 and has sel high from cycle 3.
- Async reset: assert rst mid-message in cycle 2 between clock edges -> sel, shift, done, cell_busy, rr_ptr go to 0 immediately, without waiting for a clock edge.
